// File: rtl/usb_rx_fsm.sv
`default_nettype none
// usb_rx_fsm: USB full-speed RX packet controller (SYNC/PID check, payload buffering, CRC16).
// Optional RX_TOKEN_CRC5_EN: check CRC5 on token packets.  Rev 1.0
module usb_rx_fsm #(
  parameter int MAX_DATA = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       byte_received,
  input  logic [7:0] rcv_data,
  input  logic       eop_detected,
  output logic       rx_transfer_active,
  output logic [2:0] rx_packet,
  output logic       rx_data_ready,
  output logic       rx_error,
  output logic       flush,
  output logic       store_rx_packet_data,
  output logic [7:0] rx_packet_data,
  output logic [6:0] rx_data_size
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PID_WAIT = 3'd1,
    S_TOKEN    = 3'd2,
    S_HS_EOP   = 3'd3,
    S_DATA     = 3'd4,
    S_ERR_WAIT = 3'd5,
    S_DONE     = 3'd6,
    S_ERROR    = 3'd7
  } state_t;

  localparam logic [2:0]  PKT_OUT   = 3'd1;
  localparam logic [2:0]  PKT_IN    = 3'd2;
  localparam logic [2:0]  PKT_DATA0 = 3'd3;
  localparam logic [2:0]  PKT_DATA1 = 3'd4;
  localparam logic [2:0]  PKT_ACK   = 3'd5;
  localparam logic [2:0]  PKT_NAK   = 3'd6;
  localparam logic [6:0]  MAX_SIZE  = 7'(MAX_DATA);
  localparam logic [15:0] CRC16_RES = 16'h800D;

  state_t      state, st_b, state_nxt;
  logic [2:0]  pkt_nxt;
  logic [7:0]  hold0, hold1, hold0_nxt, hold1_nxt;
  logic [1:0]  cnt, cnt_nxt;
  logic [15:0] crc16, crc16_nxt;
  logic [6:0]  size_nxt;
  logic [7:0]  wdata_nxt;
  logic        flush_nxt, store_nxt, pid_ok, tok_crc_ok;

  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] d);
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      c = (c[15] ^ d[i]) ? ({c[14:0], 1'b0} ^ 16'h8005) : {c[14:0], 1'b0};
    end
    return c;
  endfunction

`ifdef RX_TOKEN_CRC5_EN
  logic [4:0] crc5, crc5_nxt;

  function automatic logic [4:0] crc5_byte(input logic [4:0] crc, input logic [7:0] d);
    logic [4:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      c = (c[4] ^ d[i]) ? ({c[3:0], 1'b0} ^ 5'h05) : {c[3:0], 1'b0};
    end
    return c;
  endfunction

  assign tok_crc_ok = (crc5_nxt == 5'h0C);
`else
  assign tok_crc_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= S_IDLE;
      rx_packet            <= 3'd0;
      hold0                <= 8'd0;
      hold1                <= 8'd0;
      cnt                  <= 2'd0;
      crc16                <= 16'hFFFF;
      flush                <= 1'b0;
      store_rx_packet_data <= 1'b0;
      rx_packet_data       <= 8'd0;
      rx_data_size         <= 7'd0;
`ifdef RX_TOKEN_CRC5_EN
      crc5                 <= 5'h1F;
`endif
    end else begin
      state                <= state_nxt;
      rx_packet            <= pkt_nxt;
      hold0                <= hold0_nxt;
      hold1                <= hold1_nxt;
      cnt                  <= cnt_nxt;
      crc16                <= crc16_nxt;
      flush                <= flush_nxt;
      store_rx_packet_data <= store_nxt;
      rx_packet_data       <= wdata_nxt;
      rx_data_size         <= size_nxt;
`ifdef RX_TOKEN_CRC5_EN
      crc5                 <= crc5_nxt;
`endif
    end
  end

  // Byte phase first, then EOP is judged on the post-byte state (simultaneous strobes).
  always_comb begin
    st_b      = state;
    pkt_nxt   = rx_packet;
    hold0_nxt = hold0;
    hold1_nxt = hold1;
    cnt_nxt   = cnt;
    crc16_nxt = crc16;
    size_nxt  = rx_data_size;
    wdata_nxt = rx_packet_data;
    flush_nxt = 1'b0;
    store_nxt = 1'b0;
    pid_ok    = (rcv_data[7:4] == ~rcv_data[3:0]);
`ifdef RX_TOKEN_CRC5_EN
    crc5_nxt  = crc5;
`endif

    if (state == S_DONE || state == S_ERROR) begin
      st_b = S_IDLE;
    end else if (byte_received) begin
      case (state)
        S_IDLE: begin
          if (rcv_data == 8'h80) st_b = S_PID_WAIT;
        end
        S_PID_WAIT: begin
          st_b = S_ERR_WAIT;
          if (pid_ok) begin
            case (rcv_data[3:0])
              4'h1, 4'h9: begin
                pkt_nxt = (rcv_data[3:0] == 4'h1) ? PKT_OUT : PKT_IN;
                st_b    = S_TOKEN;
                cnt_nxt = 2'd0;
`ifdef RX_TOKEN_CRC5_EN
                crc5_nxt = 5'h1F;
`endif
              end
              4'h3, 4'hB: begin
                pkt_nxt   = (rcv_data[3:0] == 4'h3) ? PKT_DATA0 : PKT_DATA1;
                st_b      = S_DATA;
                flush_nxt = 1'b1;
                size_nxt  = 7'd0;
                cnt_nxt   = 2'd0;
                crc16_nxt = 16'hFFFF;
              end
              4'h2, 4'hA: begin
                pkt_nxt = (rcv_data[3:0] == 4'h2) ? PKT_ACK : PKT_NAK;
                st_b    = S_HS_EOP;
              end
              default: st_b = S_ERR_WAIT;
            endcase
          end
        end
        S_TOKEN: begin
          if (cnt == 2'd2) begin
            st_b = S_ERR_WAIT;
          end else begin
            cnt_nxt = cnt + 2'd1;
`ifdef RX_TOKEN_CRC5_EN
            crc5_nxt = crc5_byte(crc5, rcv_data);
`endif
          end
        end
        S_HS_EOP: st_b = S_ERR_WAIT;
        S_DATA: begin
          // Two-byte holding register keeps the trailing CRC bytes out of the buffer.
          crc16_nxt = crc16_byte(crc16, rcv_data);
          hold0_nxt = rcv_data;
          hold1_nxt = hold0;
          if (cnt == 2'd2) begin
            if (rx_data_size == MAX_SIZE) begin
              st_b = S_ERR_WAIT;
            end else begin
              store_nxt = 1'b1;
              wdata_nxt = hold1;
              size_nxt  = rx_data_size + 7'd1;
            end
          end else begin
            cnt_nxt = cnt + 2'd1;
          end
        end
        default: ;
      endcase
    end

    state_nxt = st_b;
    if (eop_detected) begin
      case (st_b)
        S_PID_WAIT, S_ERR_WAIT: state_nxt = S_ERROR;
        S_TOKEN:  state_nxt = (cnt_nxt == 2'd2 && tok_crc_ok) ? S_DONE : S_ERROR;
        S_HS_EOP: state_nxt = S_DONE;
        S_DATA:   state_nxt = (cnt_nxt == 2'd2 && crc16_nxt == CRC16_RES) ? S_DONE : S_ERROR;
        default: ;
      endcase
    end
  end

  assign rx_transfer_active = (state == S_PID_WAIT) || (state == S_TOKEN) ||
                              (state == S_HS_EOP) || (state == S_DATA) ||
                              (state == S_ERR_WAIT);
  assign rx_data_ready      = (state == S_DONE);
  assign rx_error           = (state == S_ERROR);

endmodule
`default_nettype wire
